mult_arbiter: RTL

//  Shares one 4-bit shift-add multiplier between NUM_REQ requesters. Round-robin

---
 rtl/mult_arb_pkg.sv | 26 ++
 rtl/mult_arbiter_rr_pick.sv | 48 ++++
 rtl/mult_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
//   Shared types and constants for the multiplier arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - OPW_DEF     : default operand width
//   - PROD_W      : default product width (2 * OPW_DEF)
//   - wrap_inc()  : index + 1 modulo n, used for the round-robin pointer
// -----------------------------------------------------------------------------
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int OPW_DEF = 4;
    localparam int PROD_W  = 2 * OPW_DEF;

    // Next index after idx in a ring of n slots.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans the request vector starting at
//   the priority pointer and wrapping around; the first set bit wins.
//   Ports:
//     req_i   [N-1:0]   request vector
//     ptr_i   [IDW-1:0] index that has highest priority this cycle
//     grant_o [N-1:0]   one-hot grant (all zero when nothing requests)
//     idx_o   [IDW-1:0] index of the granted requester (0 when none)
//     any_o             at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    // Slot k positions after the pointer; p and k are both < N, so a
    // single conditional subtract replaces a general modulo.
    function automatic int slot(input int p, input int k);
        int s;
        s = p + k;
        return (s >= N) ? s - N : s;
    endfunction

    always_comb begin
        idx_o   = '0;
        any_o   = 1'b0;
        grant_o = '0;
        // Walk from the farthest slot back to the pointer so the closest
        // valid requester is the last (winning) assignment.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[slot(int'(ptr_i), k)]) begin
                idx_o = IDW'(slot(int'(ptr_i), k));
                any_o = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            grant_o[j] = any_o && (idx_o == IDW'(j));
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//   Shares one shift-add multiplier between NUM_REQ requesters. A round-robin
//   grant picks one request, its operands are captured and driven to the
//   multiplier, a one-cycle start pulse is issued, and the product returned
//   by the multiplier is presented on the response port tagged with the
//   requester index. One operation is in flight at a time.
//
//   Optional feature: define MULT_ARB_TIMEOUT_EN to bound the wait for
//   mul_ready to TIMEOUT cycles; on expiry a zero product is returned with
//   rsp_err set. Without the macro the wait is unbounded and rsp_err is 0.
//
//   Ports:
//     clk_in, rst_in          clock (posedge) / async active-low reset
//     req_valid/req_ready     per-requester handshake, ready is one-hot
//     req_x, req_y            packed operands, requester i at [i*OPW +: OPW]
//     rsp_valid/rsp_ready     response handshake
//     rsp_id, rsp_product     requester index and 2*OPW-bit product
//     rsp_err                 timeout flag
//     mul_start, mul_x, mul_y start pulse and operands to the multiplier
//     mul_product, mul_ready  result and done from the multiplier
// -----------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int OPW     = OPW_DEF,
    parameter  int TIMEOUT = 32,
    localparam int IDW     = $clog2(NUM_REQ),
    localparam int PW      = 2 * OPW
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*OPW-1:0] req_x,
    input  logic [NUM_REQ*OPW-1:0] req_y,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [PW-1:0]          rsp_product,
    output logic                   rsp_err,
    output logic                   mul_start,
    output logic [OPW-1:0]         mul_x,
    output logic [OPW-1:0]         mul_y,
    input  logic [PW-1:0]          mul_product,
    input  logic                   mul_ready
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || OPW < 1 || TIMEOUT < 1) begin : g_param_check
        $error("mult_arbiter: parameter out of range");
    end

    arb_state_t     state_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] id_q;
    logic [OPW-1:0] x_q, y_q;
    logic [PW-1:0]  prod_q;
    logic           start_q;
    logic           rsp_valid_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [OPW-1:0]     sel_x, sel_y;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Accept is only offered while idle; losers simply keep requesting.
    assign req_ready = (state_q == IDLE) ? pick_grant : '0;

    assign sel_x = req_x[pick_idx*OPW +: OPW];
    assign sel_y = req_y[pick_idx*OPW +: OPW];

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            prod_q      <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        x_q     <= sel_x;
                        y_q     <= sel_y;
                        id_q    <= pick_idx;
                        start_q <= 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // mul_ready seen here belongs to no operation of ours.
                    start_q <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mul_ready) begin
                        prod_q      <= mul_product;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        prod_q      <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= IDW'(wrap_inc(32'(id_q), NUM_REQ));
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign mul_start   = start_q;
    assign mul_x       = x_q;
    assign mul_y       = y_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err     = err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule
